spi_ram_ctrl: RTL and testbench
===============================

// Module: spi_ram_ctrl
// PURPOSE
//  Command sequencer between spi_slave and the single-port RAM. Decodes each 10-bit
//  rx_data word (2-bit opcode + 8-bit payload), holds separate write/read address
//  registers, issues RAM write/read strobes and returns read bytes via tx_data/tx_valid.
//  Sits between the SPI slave and the RAM in the SPI wrapper.
// PARAMETERS
//  MEM_DEPTH  256  RAM words; power of two, 2..256
//  ADDR_SIZE  8    RAM address width; equals clog2(MEM_DEPTH)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          synchronous reset, active-high
//  rx_data    in   10         [9:8] opcode, [7:0] payload, from spi_slave
//  rx_valid   in   1          one-cycle strobe, rx_data valid
//  ram_en     out  1          RAM access strobe
//  ram_we     out  1          1 = write, 0 = read (qualified by ram_en)
//  ram_addr   out  ADDR_SIZE  RAM address
//  ram_wdata  out  8          RAM write data
//  ram_rdata  in   8          RAM read data, valid 1 cycle after ram_en & !ram_we
//  tx_data    out  8          read byte to spi_slave
//  tx_valid   out  1          one-cycle strobe, tx_data valid
//  busy       out  1          read sequence in progress
//  cmd_err    out  1          one-cycle strobe, command dropped or address out of range
// BEHAVIOUR
//  Single clock; reset synchronous, active-high.
//  All outputs registered. Reset value of every output is 0. wr_addr, rd_addr and the
//  tx_data holding register also reset to 0; FSM resets to IDLE.
//  Opcodes (rx_data[9:8]): 00 WR_ADDR: wr_addr <= payload; 01 WR_DATA: write payload at wr_addr;
//   10 RD_ADDR: rd_addr <= payload; 11 RD_DATA: payload ignored, read at rd_addr.
//  FSM states: IDLE -> RD_ISSUE -> RD_WAIT -> RD_SEND -> IDLE.
//   IDLE: accepts all opcodes. RD_DATA is the only opcode that leaves IDLE (to RD_ISSUE).
//   RD_ISSUE: ram_en=1, ram_we=0, ram_addr=rd_addr for exactly 1 cycle.
//   RD_WAIT: capture ram_rdata into the tx_data register.
//   RD_SEND: tx_valid=1 for 1 cycle; tx_data then holds until the next RD_SEND.
//  Latency: WR_DATA sampled at edge N -> ram_en=ram_we=1, ram_addr=wr_addr, ram_wdata=payload
//   during cycle N+1 only. RD_DATA sampled at edge N -> ram_en during cycle N+1,
//   tx_valid during cycle N+3.
//  busy=1 in RD_ISSUE, RD_WAIT and RD_SEND.
//  rx_valid while busy: command dropped, no state change, cmd_err pulses the next cycle.
//  Address payload >= MEM_DEPTH (MEM_DEPTH<256 only): register unchanged, cmd_err pulses.
//  wr_addr and rd_addr are independent. WR_DATA with no prior WR_ADDR uses wr_addr=0.
//  Reset mid-read: sequence abandoned, tx_valid not raised, outputs return to 0.
//  Back-to-back writes: each rx_valid in IDLE gives one RAM write pulse.
// CONFIGURATION
//  SPI_RAM_AUTOINC_EN defined: after each WR_DATA wr_addr += 1. After each RD_ISSUE
//   rd_addr += 1. Both wrap MEM_DEPTH-1 -> 0.
//  SPI_RAM_AUTOINC_EN undefined: addresses change only on WR_ADDR / RD_ADDR.
// STRUCTURE
//  Package spi_ram_pkg: opcode constants (OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01,
//   OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11), FSM state encoding (2-bit),
//   CMD_W=10, DATA_W=8. Shared with spi_slave and its bench.
//  No sub-module: FSM + address registers fit one module. The RAM stays external.
// TESTING
//  1 WR_ADDR 0x10, WR_DATA 0xA5 -> one-cycle ram_en=ram_we=1, ram_addr=0x10,
//    ram_wdata=0xA5, tx_valid stays 0.
//  2 Then RD_ADDR 0x10, RD_DATA (RAM model returns 0xA5) -> ram_en=1/ram_we=0 at N+1,
//    tx_valid=1 with tx_data=0xA5 at N+3, busy high N+1..N+3.
//  3 RD_DATA, then WR_DATA 0x3C one cycle later (busy) -> write dropped, no ram_we pulse,
//    cmd_err=1 one cycle, read completes normally.
//  4 rst=1 in the cycle after RD_ISSUE -> tx_valid never asserts, busy=0, all outputs 0
//    next cycle; a following read works.
//  5 AUTOINC_EN, WR_ADDR 0xFF (MEM_DEPTH=256), WR_DATA 0x11, WR_DATA 0x22 ->
//    writes at 0xFF then 0x00. Without the macro both writes hit 0xFF.
//  6 MEM_DEPTH=64, WR_ADDR 0x50 -> cmd_err=1, wr_addr unchanged (0), next WR_DATA
//    writes address 0x00.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI-to-RAM command path: opcodes, word widths, FSM encoding.
// Used by spi_ram_ctrl, spi_slave and their benches.
package spi_ram_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_SEND  = 2'd3
  } ctrl_state_e;

  function automatic logic [1:0] cmd_op(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_W-1 -: 2];
  endfunction

  function automatic logic [DATA_W-1:0] cmd_payload(input logic [CMD_W-1:0] cmd);
    return cmd[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command/RAM/response bundle around spi_ram_ctrl. slave = controller side,
// master = the SPI slave + RAM side that feeds commands and read data.
interface spi_ram_ctrl_if import spi_ram_pkg::*; #(parameter int ADDR_SIZE = 8);

  logic [CMD_W-1:0]     rx_data;
  logic                 rx_valid;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [DATA_W-1:0]    ram_rdata;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_valid;
  logic                 busy;
  logic                 cmd_err;

  modport slave (
    input  rx_data, rx_valid, ram_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, tx_data, tx_valid, busy, cmd_err
  );

  modport master (
    output rx_data, rx_valid, ram_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, tx_data, tx_valid, busy, cmd_err
  );

endinterface

// File: rtl/spi_ram_ctrl.sv
// Command sequencer between spi_slave and a single-port RAM; all outputs registered.
// Optional SPI_RAM_AUTOINC_EN: post-increment wr_addr on WR_DATA and rd_addr on RD_ISSUE.
module spi_ram_ctrl import spi_ram_pkg::*; #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_ram_ctrl_if.slave  bus
);

  ctrl_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 cmd_err_q, cmd_err_d;

  logic [1:0]           op;
  logic [DATA_W-1:0]    payload;
  logic                 in_range;

  assign op       = cmd_op(bus.rx_data);
  assign payload  = cmd_payload(bus.rx_data);
  // Only reachable when MEM_DEPTH < 256; for the full map every payload is legal.
  assign in_range = (int'(payload) < MEM_DEPTH);

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (op)
            OP_WR_ADDR: begin
              if (in_range) wr_addr_d = payload[ADDR_SIZE-1:0];
              else          cmd_err_d = 1'b1;
            end
            OP_WR_DATA: begin
              ram_en_d    = 1'b1;
              ram_we_d    = 1'b1;
              ram_addr_d  = wr_addr_q;
              ram_wdata_d = payload;
`ifdef SPI_RAM_AUTOINC_EN
              wr_addr_d   = wr_addr_q + ADDR_SIZE'(1);
`endif
            end
            OP_RD_ADDR: begin
              if (in_range) rd_addr_d = payload[ADDR_SIZE-1:0];
              else          cmd_err_d = 1'b1;
            end
            default: begin
              ram_en_d   = 1'b1;
              ram_addr_d = rd_addr_q;
              state_d    = ST_RD_ISSUE;
            end
          endcase
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
`ifdef SPI_RAM_AUTOINC_EN
        rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
`endif
      end
      ST_RD_WAIT: begin
        // RAM data is valid now; register it so tx_valid and tx_data rise together.
        tx_data_d  = bus.ram_rdata;
        tx_valid_d = 1'b1;
        state_d    = ST_RD_SEND;
      end
      ST_RD_SEND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && bus.rx_valid) cmd_err_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: full-map instance with RAM model and scoreboard,
// plus a MEM_DEPTH=64 instance for address range errors.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  spi_ram_ctrl_if #(.ADDR_SIZE(8)) a ();
  spi_ram_ctrl_if #(.ADDR_SIZE(6)) b ();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_full  (.clk(clk), .rst(rst), .bus(a));
  spi_ram_ctrl #(.MEM_DEPTH(64),  .ADDR_SIZE(6)) u_small (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model for the full-map instance
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (a.ram_en) begin
      if (a.ram_we) mem[a.ram_addr] <= a.ram_wdata;
      else          a.ram_rdata     <= mem[a.ram_addr];
    end
  end
  assign b.ram_rdata = 8'h00;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ram_ev_t;

  ram_ev_t    ram_q[$];
  logic [7:0] tx_q[$];
  int         exp_err = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wr, ref_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (a.ram_en === 1'b1) begin
      if (ram_q.size() == 0) chk("ram_unexpected", 32'(a.ram_en), 32'd0);
      else begin
        ram_ev_t e;
        e = ram_q.pop_front();
        chk("sb_ram_we", 32'(a.ram_we), 32'(e.we));
        chk("sb_ram_addr", 32'(a.ram_addr), 32'(e.addr));
        if (e.we) chk("sb_ram_wdata", 32'(a.ram_wdata), 32'(e.wdata));
      end
    end
    if (a.tx_valid === 1'b1) begin
      if (tx_q.size() == 0) chk("tx_unexpected", 32'(a.tx_valid), 32'd0);
      else begin
        logic [7:0] d;
        d = tx_q.pop_front();
        chk("sb_tx_data", 32'(a.tx_data), 32'(d));
      end
    end
    if (a.cmd_err === 1'b1) begin
      chk("cmd_err_expected", 32'(exp_err > 0), 32'd1);
      if (exp_err > 0) exp_err--;
    end
  end

  // Called at a negedge; returns at the next negedge (cycle N+1 after sampling edge N).
  task automatic send(input logic [1:0] op, input logic [7:0] p);
    a.rx_data  = {op, p};
    a.rx_valid = 1'b1;
    @(negedge clk);
    a.rx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] op, input logic [7:0] p);
    b.rx_data  = {op, p};
    b.rx_valid = 1'b1;
    @(negedge clk);
    b.rx_valid = 1'b0;
  endtask

  task automatic do_wr_addr(input logic [7:0] p);
    ref_wr = p;
    send(OP_WR_ADDR, p);
  endtask

  task automatic do_rd_addr(input logic [7:0] p);
    ref_rd = p;
    send(OP_RD_ADDR, p);
  endtask

  task automatic do_wr_data(input logic [7:0] d);
    ram_q.push_back('{we: 1'b1, addr: ref_wr, wdata: d});
    ref_mem[ref_wr] = d;
`ifdef SPI_RAM_AUTOINC_EN
    ref_wr = ref_wr + 8'd1;
`endif
    send(OP_WR_DATA, d);
  endtask

  task automatic do_rd_data(input bit expect_tx);
    ram_q.push_back('{we: 1'b0, addr: ref_rd, wdata: 8'h00});
    if (expect_tx) tx_q.push_back(ref_mem[ref_rd]);
`ifdef SPI_RAM_AUTOINC_EN
    ref_rd = ref_rd + 8'd1;
`endif
    send(OP_RD_DATA, 8'h00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_en"},    32'(a.ram_en),    32'd0);
    chk({tag, "_ram_we"},    32'(a.ram_we),    32'd0);
    chk({tag, "_ram_addr"},  32'(a.ram_addr),  32'd0);
    chk({tag, "_ram_wdata"}, 32'(a.ram_wdata), 32'd0);
    chk({tag, "_tx_data"},   32'(a.tx_data),   32'd0);
    chk({tag, "_tx_valid"},  32'(a.tx_valid),  32'd0);
    chk({tag, "_busy"},      32'(a.busy),      32'd0);
    chk({tag, "_cmd_err"},   32'(a.cmd_err),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a.rx_valid = 1'b0; a.rx_data = '0;
    b.rx_valid = 1'b0; b.rx_data = '0;
    ref_wr = 8'h00; ref_rd = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_b_busy", 32'(b.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // WR_DATA with no prior WR_ADDR lands at address 0
    do_wr_data(8'h5A);
    chk("t0_ram_en", 32'(a.ram_en), 32'd1);
    chk("t0_ram_addr", 32'(a.ram_addr), 32'h00);

    // 1: address + data write, single pulse
    do_wr_addr(8'h10);
    chk("t1_addr_no_en", 32'(a.ram_en), 32'd0);
    do_wr_data(8'hA5);
    chk("t1_ram_en", 32'(a.ram_en), 32'd1);
    chk("t1_ram_we", 32'(a.ram_we), 32'd1);
    chk("t1_ram_addr", 32'(a.ram_addr), 32'h10);
    chk("t1_ram_wdata", 32'(a.ram_wdata), 32'hA5);
    chk("t1_tx_valid", 32'(a.tx_valid), 32'd0);
    @(negedge clk);
    chk("t1_pulse_end", 32'(a.ram_en), 32'd0);

    // 2: read-back with latency and busy window
    do_rd_addr(8'h10);
    do_rd_data(1'b1);
    chk("t2_n1_ram_en", 32'(a.ram_en), 32'd1);
    chk("t2_n1_ram_we", 32'(a.ram_we), 32'd0);
    chk("t2_n1_ram_addr", 32'(a.ram_addr), 32'h10);
    chk("t2_n1_busy", 32'(a.busy), 32'd1);
    @(negedge clk);
    chk("t2_n2_busy", 32'(a.busy), 32'd1);
    chk("t2_n2_ram_en", 32'(a.ram_en), 32'd0);
    chk("t2_n2_tx_valid", 32'(a.tx_valid), 32'd0);
    @(negedge clk);
    chk("t2_n3_tx_valid", 32'(a.tx_valid), 32'd1);
    chk("t2_n3_tx_data", 32'(a.tx_data), 32'hA5);
    chk("t2_n3_busy", 32'(a.busy), 32'd1);
    @(negedge clk);
    chk("t2_n4_tx_valid", 32'(a.tx_valid), 32'd0);
    chk("t2_n4_busy", 32'(a.busy), 32'd0);
    chk("t2_n4_tx_hold", 32'(a.tx_data), 32'hA5);

    // 3: write while busy is dropped with cmd_err
    do_rd_addr(8'h10);
    do_rd_data(1'b1);
    exp_err++;
    send(OP_WR_DATA, 8'h3C);
    chk("t3_cmd_err", 32'(a.cmd_err), 32'd1);
    chk("t3_no_write", 32'(a.ram_en), 32'd0);
    @(negedge clk);
    chk("t3_tx_valid", 32'(a.tx_valid), 32'd1);
    chk("t3_tx_data", 32'(a.tx_data), 32'hA5);
    chk("t3_cmd_err_end", 32'(a.cmd_err), 32'd0);
    @(negedge clk);

    // 4: reset in RD_WAIT abandons the read
    do_rd_addr(8'h10);
    do_rd_data(1'b0);
    chk("t4_issue", 32'(a.ram_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("t4_rst");
    rst = 1'b0;
    ref_wr = 8'h00; ref_rd = 8'h00;
    @(negedge clk);
    chk("t4_no_tx", 32'(a.tx_valid), 32'd0);
    do_rd_data(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_reread_tx_valid", 32'(a.tx_valid), 32'd1);
    chk("t4_reread_tx_data", 32'(a.tx_data), 32'h5A);
    @(negedge clk);

    // 5: top-of-map writes, wrap only with auto-increment
    do_wr_addr(8'hFF);
    do_wr_data(8'h11);
    chk("t5_w1_addr", 32'(a.ram_addr), 32'hFF);
    do_wr_data(8'h22);
`ifdef SPI_RAM_AUTOINC_EN
    chk("t5_w2_addr", 32'(a.ram_addr), 32'h00);
`else
    chk("t5_w2_addr", 32'(a.ram_addr), 32'hFF);
`endif
    chk("t5_w2_wdata", 32'(a.ram_wdata), 32'h22);
    @(negedge clk);

    // 6: MEM_DEPTH=64 range errors
    send_b(OP_WR_ADDR, 8'h50);
    chk("t6_oor_err", 32'(b.cmd_err), 32'd1);
    @(negedge clk);
    chk("t6_err_pulse", 32'(b.cmd_err), 32'd0);
    send_b(OP_WR_DATA, 8'h77);
    chk("t6_w_en", 32'(b.ram_en), 32'd1);
    chk("t6_w_addr", 32'(b.ram_addr), 32'h00);
    chk("t6_w_wdata", 32'(b.ram_wdata), 32'h77);
    send_b(OP_WR_ADDR, 8'h3F);
    chk("t6_edge_no_err", 32'(b.cmd_err), 32'd0);
    send_b(OP_WR_DATA, 8'h12);
    chk("t6_edge_addr", 32'(b.ram_addr), 32'h3F);
    send_b(OP_RD_ADDR, 8'h40);
    chk("t6_rd_oor_err", 32'(b.cmd_err), 32'd1);

    repeat (2) @(negedge clk);
    chk("end_ram_q_empty", 32'(ram_q.size()), 32'd0);
    chk("end_tx_q_empty", 32'(tx_q.size()), 32'd0);
    chk("end_err_drained", 32'(exp_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
